mmio_timer_resp: RTL and testbench

Memory-mapped timer peripheral that acts as a responder on the CPU data-memory port, alongside the main memory. It decodes a fixed 32-byte I/O window, serves reads and writes to five 32-bit registers, and runs a prescaled up-counter with compare-match. It raises a level interrupt flag for the control unit's exception path. The CPU top-level muxes `ReadData` against memory data using `Hit`.

---
 rtl/mmio_timer_resp.sv | 161 ++++++++++++++++
 tb/tb_mmio_timer_resp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_resp.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_timer_resp
//  Description : Memory-mapped timer responder for the CPU data-memory port.
//                Decodes a 32-byte window at BASE_ADDR and serves five 32-bit
//                registers: COUNT, COMPARE, CTRL, STATUS and PRESCALE. It runs
//                an up-counter with compare-match, optional autoreload and a
//                level interrupt.
//                Define MMIO_TIMER_PRESCALE_EN to build the 16-bit prescaler
//                and the PRESCALE register. Without it the counter ticks on
//                every enabled cycle and offset 4 reads as unmapped.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer_resp #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] WriteData,
    output logic        Hit,
    output logic [31:0] ReadData,
    output logic        Irq
);

    localparam logic [2:0] c_OFF_COUNT    = 3'd0;
    localparam logic [2:0] c_OFF_COMPARE  = 3'd1;
    localparam logic [2:0] c_OFF_CTRL     = 3'd2;
    localparam logic [2:0] c_OFF_STATUS   = 3'd3;
    localparam logic [2:0] c_OFF_PRESCALE = 3'd4;

    // Architectural state
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [2:0]  r_ctrl;        // {IRQ_EN, AUTORELOAD, EN}
    logic        r_match;
    logic [31:0] r_read_data;
    logic        r_irq;

    // Decode and datapath wires
    logic [2:0]  w_offset;
    logic        w_wr_en;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_match_now;
    logic        w_status_clr;
    logic [31:0] w_prescale_rd;
    logic [31:0] w_read_mux;
    logic        w_unused;

    // Byte lane bits are irrelevant for word-wide registers
    assign w_unused = ^Address[1:0];

    assign Hit          = (Address[31:5] == BASE_ADDR[31:5]);
    assign w_offset     = Address[4:2];
    assign w_wr_en      = Wr & Hit;
    assign w_wr_count   = w_wr_en && (w_offset == c_OFF_COUNT);
    assign w_wr_compare = w_wr_en && (w_offset == c_OFF_COMPARE);
    assign w_wr_ctrl    = w_wr_en && (w_offset == c_OFF_CTRL);
    assign w_wr_status  = w_wr_en && (w_offset == c_OFF_STATUS);
    assign w_status_clr = w_wr_status & WriteData[0];
    assign w_match_now  = w_tick && (r_count == r_compare);

`ifdef MMIO_TIMER_PRESCALE_EN
    logic [15:0] r_prescale;
    logic [15:0] r_pcnt;
    logic        w_wr_prescale;

    assign w_wr_prescale = w_wr_en && (w_offset == c_OFF_PRESCALE);
    assign w_tick        = r_ctrl[0] && (r_pcnt == r_prescale);
    assign w_prescale_rd = {16'd0, r_prescale};

    // Prescaler: divides the clock by PRESCALE+1 while enabled; a new
    // PRESCALE value restarts the division from zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prescale <= 16'd0;
            r_pcnt     <= 16'd0;
        end else if (w_wr_prescale) begin
            r_prescale <= WriteData[15:0];
            r_pcnt     <= 16'd0;
        end else if (r_ctrl[0]) begin
            r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
        end
    end
`else
    assign w_tick        = r_ctrl[0];
    assign w_prescale_rd = 32'd0;
`endif

    // Up-counter: CPU write has priority over the tick update
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= 32'd0;
        end else if (w_wr_count) begin
            r_count <= WriteData;
        end else if (w_tick) begin
            r_count <= (w_match_now && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
        end
    end

    // Configuration registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_compare <= 32'd0;
            r_ctrl    <= 3'd0;
        end else begin
            if (w_wr_compare) r_compare <= WriteData;
            if (w_wr_ctrl)    r_ctrl    <= WriteData[2:0];
        end
    end

    // Sticky match flag: a new match beats a simultaneous write-1-to-clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_match_now | (r_match & ~w_status_clr);
        end
    end

    // Register read multiplexer; unmapped offsets return zero
    always_comb begin
        w_read_mux = 32'd0;
        case (w_offset)
            c_OFF_COUNT:    w_read_mux = r_count;
            c_OFF_COMPARE:  w_read_mux = r_compare;
            c_OFF_CTRL:     w_read_mux = {29'd0, r_ctrl};
            c_OFF_STATUS:   w_read_mux = {31'd0, r_match};
            c_OFF_PRESCALE: w_read_mux = w_prescale_rd;
            default:        w_read_mux = 32'd0;
        endcase
    end

    // One-cycle read data to line up with the main memory's latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_read_data <= 32'd0;
        end else begin
            r_read_data <= (Hit & ~Wr) ? w_read_mux : 32'd0;
        end
    end

    // Interrupt level lags the match flag by one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_match & r_ctrl[2];
        end
    end

    assign ReadData = r_read_data;
    assign Irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_timer_resp
//  Description : Self-checking bench for mmio_timer_resp: register readback
//                vectors, timing sequences for autoreload, wrap, W1C-vs-set,
//                write-vs-tick and mid-run reset, then random traffic against
//                a behavioural register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_timer_resp;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef MMIO_TIMER_PRESCALE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = 32'd0;
    logic        Wr = 1'b0;
    logic [31:0] WriteData = 32'd0;
    logic        Hit;
    logic [31:0] ReadData;
    logic        Irq;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_timer_resp #(.BASE_ADDR(BASE)) dut (
        .clock     (clock),
        .reset     (reset),
        .Address   (Address),
        .Wr        (Wr),
        .WriteData (WriteData),
        .Hit       (Hit),
        .ReadData  (ReadData),
        .Irq       (Irq)
    );

    always #5 clock = ~clock;

    // Behavioural model of the register file
    logic [31:0] m_count, m_compare, m_rd;
    logic [2:0]  m_ctrl;
    logic        m_match, m_irq, m_hit;
    logic [15:0] m_pre, m_pcnt;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int off);
        case (off)
            0: return m_count;
            1: return m_compare;
            2: return {29'd0, m_ctrl};
            3: return {31'd0, m_match};
            4: return PRE ? {16'd0, m_pre} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_ctrl = 0; m_match = 0;
        m_pre = 0; m_pcnt = 0; m_rd = 0; m_irq = 0; m_hit = 0;
    endtask

    // Advance the model across one clock edge with the given bus request
    task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
        int          off;
        bit          tick, hit, set, clr;
        logic [31:0] n_count;
        logic [15:0] n_pcnt;
        hit  = ((a & 32'hFFFF_FFE0) == (BASE & 32'hFFFF_FFE0));
        off  = int'((a >> 2) & 32'd7);
        tick = m_ctrl[0] && (!PRE || (m_pcnt == m_pre));
        set  = tick && (m_count == m_compare);
        clr  = hit && w && (off == 3) && d[0];
        n_pcnt  = m_pcnt;
        if (PRE && m_ctrl[0]) n_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
        n_count = m_count;
        if (tick) n_count = (set && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
        m_irq = m_match & m_ctrl[2];
        m_rd  = (hit && !w) ? m_read(off) : 32'd0;
        m_hit = hit;
        if (hit && w) begin
            case (off)
                0: n_count = d;
                1: m_compare = d;
                2: m_ctrl = d[2:0];
                4: if (PRE) begin m_pre = d[15:0]; n_pcnt = 16'd0; end
                default: ;
            endcase
        end
        m_match = set | (m_match & ~clr);
        m_count = n_count;
        m_pcnt  = n_pcnt;
    endtask

    // One bus cycle: drive, sample Hit before the edge, return after the edge
    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d, output logic hs);
        Address = a; Wr = w; WriteData = d;
        model_step(a, w, d);
        #1;
        hs = Hit;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0; Address = BASE; Wr = 1'b0; WriteData = 32'd0;
        #1;
        check("reset_rd", ReadData, 32'd0);
        check("reset_irq", {31'd0, Irq}, 32'd0);
        check("reset_hit", {31'd0, Hit}, 32'd1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic hs;
        int   d, p;
        bit   m, w;
        logic [31:0] exp_rd;

        // ---------------- readback vectors ----------------
        for (int i = 0; i < 8; i++)
            vecs.push_back('{BASE + 32'(4 * i), 1'b0, 32'd0, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h04, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h04, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{BASE - 32'd4, 1'b0, 32'd0, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h24, 1'b1, 32'h1234_5678, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h07, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{BASE + 32'h08, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h08, 1'b0, 32'd0, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h08, 1'b1, 32'h0000_0006, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h0A, 1'b0, 32'd0, 1'b1, 32'd6});
        vecs.push_back('{BASE + 32'h10, 1'b1, 32'd7, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h10, 1'b0, 32'd0, 1'b1, PRE ? 32'd7 : 32'd0});
        vecs.push_back('{BASE + 32'h10, 1'b1, 32'hABCD_1234, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h10, 1'b0, 32'd0, 1'b1, PRE ? 32'h1234 : 32'd0});
        vecs.push_back('{BASE + 32'h14, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h14, 1'b0, 32'd0, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h1C, 1'b0, 32'd0, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h0C, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h0C, 1'b0, 32'd0, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h00, 1'b1, 32'd55, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h00, 1'b0, 32'd0, 1'b1, 32'd55});

        do_reset();
        foreach (vecs[i]) begin
            cyc(vecs[i].addr, vecs[i].wr, vecs[i].wdata, hs);
            check($sformatf("vec%0d_hit", i), {31'd0, hs}, {31'd0, vecs[i].exp_hit});
            check($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'd0, Irq}, 32'd0);
        end

        // ---------------- autoreload period, W1C, W1C vs set ----------------
        do_reset();
        d = PRE ? 2 : 1;
        p = 4 * d;
        cyc(BASE + 32'h10, 1'b1, 32'd1, hs);
        cyc(BASE + 32'h04, 1'b1, 32'd3, hs);
        cyc(BASE + 32'h08, 1'b1, 32'd7, hs);   // enable edge = cycle 0
        m = 1'b0;
        for (int k = 1; k <= 5 * p + 2; k++) begin
            logic exp_irq;
            w = (k == 3 * p + 1) || (k == 5 * p) || (k == 5 * p + 1);
            exp_irq = m;
            if (w) m = 1'b0;
            if (k % p == 0) m = 1'b1;
            exp_rd = w ? 32'd0 : 32'(((k - 1) / d) % 4);
            cyc(w ? BASE + 32'h0C : BASE, w, 32'd1, hs);
            check($sformatf("ar_count_k%0d", k), ReadData, exp_rd);
            check($sformatf("ar_irq_k%0d", k), {31'd0, Irq}, {31'd0, exp_irq});
        end

        // ---------------- wrap past 2^32 ----------------
        do_reset();
        cyc(BASE + 32'h00, 1'b1, 32'hFFFF_FFFE, hs);
        cyc(BASE + 32'h04, 1'b1, 32'd5, hs);
        cyc(BASE + 32'h10, 1'b1, 32'd0, hs);
        cyc(BASE + 32'h08, 1'b1, 32'd5, hs);
        for (int k = 1; k <= 10; k++) begin
            cyc(BASE, 1'b0, 32'd0, hs);
            check($sformatf("wrap_count_k%0d", k), ReadData, 32'hFFFF_FFFE + 32'(k - 1));
            check($sformatf("wrap_irq_k%0d", k), {31'd0, Irq}, (k >= 9) ? 32'd1 : 32'd0);
        end

        // ---------------- CPU write on a tick edge ----------------
        do_reset();
        d = PRE ? 4 : 1;
        cyc(BASE + 32'h10, 1'b1, 32'd3, hs);
        cyc(BASE + 32'h04, 1'b1, 32'h0000_FFFF, hs);
        cyc(BASE + 32'h08, 1'b1, 32'd1, hs);
        for (int k = 1; k <= 3 * d + 1; k++) begin
            w = (k == 2 * d);
            if (w) exp_rd = 32'd0;
            else if (k - 1 < 2 * d) exp_rd = 32'((k - 1) / d);
            else exp_rd = 32'd100 + 32'((k - 1 - 2 * d) / d);
            cyc(BASE, w, 32'd100, hs);
            check($sformatf("wvt_count_k%0d", k), ReadData, exp_rd);
        end

        // ---------------- reset in the middle of counting ----------------
        do_reset();
        cyc(BASE + 32'h04, 1'b1, 32'd2, hs);
        cyc(BASE + 32'h08, 1'b1, 32'd7, hs);
        for (int k = 1; k <= 6; k++) begin
            cyc(BASE, 1'b0, 32'd0, hs);
            check($sformatf("mr_count_k%0d", k), ReadData, 32'((k - 1) % 3));
            check($sformatf("mr_irq_k%0d", k), {31'd0, Irq}, (k >= 4) ? 32'd1 : 32'd0);
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(BASE + 32'(4 * i), 1'b0, 32'd0, hs);
            check($sformatf("mr_post_off%0d", i), ReadData, 32'd0);
        end
        for (int k = 0; k < 3; k++) cyc(BASE - 32'd4, 1'b0, 32'd0, hs);
        cyc(BASE, 1'b0, 32'd0, hs);
        check("mr_disabled_count", ReadData, 32'd0);
        check("mr_disabled_irq", {31'd0, Irq}, 32'd0);

        // ---------------- random traffic against the model ----------------
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, dat;
            int off;
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0)
                a = BASE ^ (32'h1 << $urandom_range(5, 31));
            else
                a = BASE + 32'(4 * off) + 32'($urandom_range(0, 3));
            w = ($urandom_range(0, 2) == 0);
            case (off)
                0: dat = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                      : 32'($urandom_range(0, 20));
                1: dat = 32'($urandom_range(0, 12));
                4: dat = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                default: dat = $urandom;
            endcase
            cyc(a, w, dat, hs);
            check($sformatf("rnd%0d_hit", i), {31'd0, hs}, {31'd0, m_hit});
            check($sformatf("rnd%0d_rd", i), ReadData, m_rd);
            check($sformatf("rnd%0d_irq", i), {31'd0, Irq}, {31'd0, m_irq});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
